// File: rtl/i2c_target_regs.sv
// I2C target with a small register file: 7-bit address match, pointer byte,
// auto-incrementing writes and reads. Open-drain SDA, SCL is input only.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_valid,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [PW-1:0] host_addr,
    output logic [7:0]    host_rdata
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] ADDR     = 4'd1;
    localparam logic [3:0] ADDR_ACK = 4'd2;
    localparam logic [3:0] PTR      = 4'd3;
    localparam logic [3:0] PTR_ACK  = 4'd4;
    localparam logic [3:0] WRITE    = 4'd5;
    localparam logic [3:0] WR_ACK   = 4'd6;
    localparam logic [3:0] READ     = 4'd7;
    localparam logic [3:0] RD_ACK   = 4'd8;
    localparam logic [3:0] RD_NEXT  = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic [3:0]             state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   rw_q, rw_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [PW-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [7:0]             regs_q [DEPTH];
    logic [7:0]             regs_d [DEPTH];

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    // SCL must be high on both sides of the SDA edge for a bus condition
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        case (state_q)
            IDLE: ;
            ADDR, PTR, WRITE: begin
                if (scl_rise && bit_cnt_q != 4'd8) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (state_q == WRITE && bit_cnt_q == 4'd7) begin
                        regs_d[ptr_q] = rx_byte;
                        wr_valid_d    = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = rx_byte;
                        ptr_d         = ptr_q + PW'(1);
                    end
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    if (state_q == ADDR) begin
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            state_d  = ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IDLE;
                        end
                    end else if (state_q == PTR) begin
                        ptr_d    = shift_q[PW-1:0];
                        sda_oe_d = 1'b1;
                        state_d  = PTR_ACK;
                    end else begin
                        sda_oe_d = 1'b1;
                        state_d  = WR_ACK;
                    end
                end
            end
            ADDR_ACK, PTR_ACK, WR_ACK: begin
                if (scl_fall) begin
                    bit_cnt_d = 4'd0;
                    if (state_q == ADDR_ACK && rw_q) begin
                        shift_d  = regs_q[ptr_q];
                        sda_oe_d = ~regs_q[ptr_q][7];
                        state_d  = READ;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = (state_q == ADDR_ACK) ? PTR : WRITE;
                    end
                end
            end
            READ: begin
                // bit_cnt counts bits already handed over; shift_q[7] is on the bus
                if (scl_fall) begin
                    if (bit_cnt_q == 4'd7) begin
                        sda_oe_d = 1'b0;
                        state_d  = RD_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        sda_oe_d  = ~shift_q[6];
                        shift_d   = {shift_q[6:0], 1'b0};
                    end
                end
            end
            RD_ACK: begin
                if (scl_rise) begin
                    if (!sda_s) begin
                        ptr_d   = ptr_q + PW'(1);
                        state_d = RD_NEXT;
                    end else begin
                        busy_d   = 1'b0;
                        sda_oe_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            RD_NEXT: begin
                if (scl_fall) begin
                    shift_d   = regs_q[ptr_q];
                    sda_oe_d  = ~regs_q[ptr_q][7];
                    bit_cnt_d = 4'd0;
                    state_d   = READ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged controller on a wired-AND SDA, a
// vector table, hand-written corner sequences and random traffic vs a model.
module tb_i2c_target_regs;

    localparam int Q     = 5;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       ctrl_sda;
    logic       sda_bus;
    logic       sda_oe, busy, wr_valid;
    logic [3:0] wr_addr, host_addr;
    logic [7:0] wr_data, host_rdata;

    assign sda_bus = ctrl_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl),
        .sda_i      (sda_bus),
        .sda_oe     (sda_oe),
        .busy       (busy),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .host_addr  (host_addr),
        .host_rdata (host_rdata)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
        logic [3:0] exp_idx;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_regs [DEPTH];
    int         model_ptr;
    logic [7:0] data_buf [4];
    wr_t        wr_obs [$];
    wr_t        wr_exp [$];
    int         oe_glitch = 0;
    int         oe_rises  = 0;
    logic       oe_prev   = 1'b0;
    logic       mon_en    = 1'b1;

    always @(negedge clk) begin
        if (wr_valid) wr_obs.push_back(wr_t'{wr_addr, wr_data});
        if (mon_en && scl && (sda_oe != oe_prev)) oe_glitch <= oe_glitch + 1;
        if (sda_oe && !oe_prev) oe_rises <= oe_rises + 1;
        oe_prev <= sda_oe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s, output logic oe);
        ctrl_sda = b;
        wait_q();
        scl = 1'b1;
        wait_q();
        s  = sda_bus;
        oe = sda_oe;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        ctrl_sda = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        ctrl_sda = 1'b0;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        ctrl_sda = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        ctrl_sda = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s, oe;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s, oe);
        clk_bit(1'b1, s, oe);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b, output logic oe9);
        logic s, oe;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s, oe);
            b = {b[6:0], s};
        end
        clk_bit(~ack, s, oe9);
    endtask

    task automatic check_reg(input int idx, input logic [7:0] exp);
        host_addr = 4'(idx);
        #1;
        check($sformatf("host_rdata[%0d]", idx), host_rdata, exp);
    endtask

    task automatic compare_writes();
        check("wr_count", wr_obs.size(), wr_exp.size());
        for (int i = 0; i < wr_obs.size() && i < wr_exp.size(); i++)
            check($sformatf("wr_event%0d", i), wr_obs[i], wr_exp[i]);
        wr_obs.delete();
        wr_exp.delete();
    endtask

    task automatic tx_write(input logic [7:0] p, input int n);
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack);
        check("wr_dev_ack", ack, 1);
        write_byte(p, ack);
        check("wr_ptr_ack", ack, 1);
        model_ptr = int'(p) % DEPTH;
        for (int i = 0; i < n; i++) begin
            write_byte(data_buf[i], ack);
            check("wr_data_ack", ack, 1);
            wr_exp.push_back(wr_t'{4'(model_ptr), data_buf[i]});
            model_regs[model_ptr] = data_buf[i];
            model_ptr = (model_ptr + 1) % DEPTH;
        end
        check("wr_busy_before_stop", busy, 1);
        i2c_stop();
        check("wr_busy_after_stop", busy, 0);
        compare_writes();
        $display("[TB] txn write ptr=%02h bytes=%0d", p, n);
    endtask

    task automatic tx_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic       ack, oe9;
        logic [7:0] b;
        if (set_ptr) begin
            i2c_start();
            write_byte(8'hA0, ack);
            check("rd_wdev_ack", ack, 1);
            write_byte(p, ack);
            check("rd_ptr_ack", ack, 1);
            model_ptr = int'(p) % DEPTH;
        end
        i2c_start();
        write_byte(8'hA1, ack);
        check("rd_dev_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, b, oe9);
            check($sformatf("rd_byte%0d", i), b, model_regs[model_ptr]);
            check("rd_ack_bit_released", oe9, 0);
            if (i != n - 1) model_ptr = (model_ptr + 1) % DEPTH;
        end
        check("rd_busy_after_nack", busy, 0);
        i2c_stop();
        compare_writes();
        $display("[TB] txn read setptr=%0d ptr=%02h bytes=%0d", set_ptr, p, n);
    endtask

    initial begin
        vec_t       vecs [6];
        logic       ack, a2, a3, s, oe;
        int         r0, kind, n;
        logic [7:0] p;

        vecs[0] = '{8'hA0, 8'h03, 8'h5A, 1'b1, 4'd3};
        vecs[1] = '{8'hA2, 8'h04, 8'h77, 1'b0, 4'd0};
        vecs[2] = '{8'hA0, 8'h1F, 8'h11, 1'b1, 4'd15};
        vecs[3] = '{8'hA0, 8'h00, 8'h22, 1'b1, 4'd0};
        vecs[4] = '{8'hA4, 8'h09, 8'h33, 1'b0, 4'd0};
        vecs[5] = '{8'hA0, 8'hF8, 8'h6B, 1'b1, 4'd8};

        for (int i = 0; i < DEPTH; i++) model_regs[i] = 8'h00;
        model_ptr = 0;

        rst = 1'b1; scl = 1'b1; ctrl_sda = 1'b1; host_addr = 4'd0;
        repeat (4) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_host_rdata", host_rdata, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single-byte write vectors, including mismatched addresses.
        for (int v = 0; v < 6; v++) begin
            r0 = oe_rises;
            i2c_start();
            write_byte(vecs[v].dev, ack);
            write_byte(vecs[v].ptr, a2);
            write_byte(vecs[v].data, a3);
            i2c_stop();
            check($sformatf("vec%0d_dev_ack", v), ack, vecs[v].exp_ack);
            check($sformatf("vec%0d_ptr_ack", v), a2, vecs[v].exp_ack);
            check($sformatf("vec%0d_data_ack", v), a3, vecs[v].exp_ack);
            check($sformatf("vec%0d_busy", v), busy, 0);
            if (vecs[v].exp_ack) begin
                check($sformatf("vec%0d_wr_count", v), wr_obs.size(), 1);
                if (wr_obs.size() > 0)
                    check($sformatf("vec%0d_wr_event", v), wr_obs[0],
                          wr_t'{vecs[v].exp_idx, vecs[v].data});
                check_reg(int'(vecs[v].exp_idx), vecs[v].data);
                model_regs[vecs[v].exp_idx] = vecs[v].data;
                model_ptr = (int'(vecs[v].exp_idx) + 1) % DEPTH;
            end else begin
                check($sformatf("vec%0d_wr_count", v), wr_obs.size(), 0);
                check($sformatf("vec%0d_no_oe", v), oe_rises - r0, 0);
            end
            wr_obs.delete();
            $display("[TB] txn vector %0d dev=%02h ptr=%02h data=%02h ack=%0d", v,
                     vecs[v].dev, vecs[v].ptr, vecs[v].data, ack);
        end

        // Two-byte write then random read of the same two registers.
        data_buf[0] = 8'h5A; data_buf[1] = 8'hC3;
        tx_write(8'h03, 2);
        check_reg(3, 8'h5A);
        check_reg(4, 8'hC3);
        tx_read(1'b1, 8'h03, 2);

        // Pointer wrap on write and read.
        data_buf[0] = 8'h11; data_buf[1] = 8'h22;
        tx_write(8'h0F, 2);
        check_reg(15, 8'h11);
        check_reg(0, 8'h22);
        tx_read(1'b1, 8'h0F, 2);

        // Abort mid-byte with STOP, then a normal address, then a pointer-less read.
        data_buf[0] = 8'hE7;
        tx_write(8'h05, 1);
        i2c_start();
        write_byte(8'hA0, ack);
        check("abort_dev_ack", ack, 1);
        write_byte(8'h05, ack);
        check("abort_ptr_ack", ack, 1);
        model_ptr = 5;
        clk_bit(1'b1, s, oe);
        clk_bit(1'b0, s, oe);
        clk_bit(1'b1, s, oe);
        clk_bit(1'b1, s, oe);
        i2c_stop();
        check("abort_sda_oe", sda_oe, 0);
        check("abort_busy", busy, 0);
        compare_writes();
        $display("[TB] txn abort after 4 data bits");
        i2c_start();
        write_byte(8'hA0, ack);
        check("abort_readdr_ack", ack, 1);
        i2c_stop();
        $display("[TB] txn address-only after abort");
        tx_read(1'b0, 8'h00, 1);

        // Random traffic against the model.
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 4);
            p    = 8'($urandom_range(0, 255));
            if (kind == 0) begin
                for (int i = 0; i < 4; i++) data_buf[i] = 8'($urandom_range(0, 255));
                tx_write(p, n);
            end else begin
                tx_read(kind == 1, p, n);
            end
        end
        for (int i = 0; i < DEPTH; i++) check_reg(i, model_regs[i]);
        check("oe_change_while_scl_high", oe_glitch, 0);

        // Reset while the target is pulling SDA low for a read data bit.
        data_buf[0] = 8'h12;
        tx_write(8'h07, 1);
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h07, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        check("rstmid_addr_ack", ack, 1);
        check("rstmid_oe_before", sda_oe, 1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_oe_after", sda_oe, 0);
        check("rstmid_busy", busy, 0);
        for (int i = 0; i < DEPTH; i++) check_reg(i, 8'h00);
        for (int i = 0; i < DEPTH; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        i2c_stop();
        wr_obs.delete();
        mon_en = 1'b1;
        $display("[TB] txn reset during read");
        tx_read(1'b0, 8'h00, 1);
        data_buf[0] = 8'h9C;
        tx_write(8'h02, 1);
        check_reg(2, 8'h9C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
